// File: rtl/biu_arbiter.sv
// Two-requester BIU arbiter (instruction fetch vs. execution unit) with EU lock support.
// Define BIU_RR_ARB_EN for round-robin arbitration; default is fixed EU-over-fetch priority.
module biu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_f,
  input  logic [1:0] sel_f,
  input  logic [1:0] op_sel_f,
  output logic       gnt_f,
  output logic       done_f,
  input  logic       req_e,
  input  logic [1:0] sel_e,
  input  logic [1:0] op_sel_e,
  output logic       gnt_e,
  output logic       done_e,
  input  logic       lock_e,
  output logic       cs_biu,
  output logic [1:0] sel,
  output logic [1:0] op_sel,
  input  logic       ready_biu,
  output logic       busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic OwnF = 1'b0;
  localparam logic OwnE = 1'b1;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] op_sel_q, op_sel_d;
  logic       cs_q, gnt_f_q, gnt_e_q, done_f_q, done_e_q, busy_q;
  logic       pick_e;

`ifdef BIU_RR_ARB_EN
  logic last_q, last_d;

  // On a tie the requester not served last wins; reset favours the EU.
  assign pick_e = req_e & (~req_f | (last_q == OwnF));

  always_comb begin
    last_d = last_q;
    if (state_q == StDone) begin
      last_d = owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OwnF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_e = req_e;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    sel_d    = sel_q;
    op_sel_d = op_sel_q;
    unique case (state_q)
      StIdle: begin
        if (req_f || req_e) begin
          owner_d  = pick_e ? OwnE : OwnF;
          sel_d    = pick_e ? sel_e : sel_f;
          op_sel_d = pick_e ? op_sel_e : op_sel_f;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (!ready_biu) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (ready_biu) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Locked EU continuation skips arbitration and the idle cycle.
        if (owner_q == OwnE && lock_e && req_e) begin
          sel_d    = sel_e;
          op_sel_d = op_sel_e;
          state_d  = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= OwnF;
      sel_q    <= 2'b00;
      op_sel_q <= 2'b00;
      cs_q     <= 1'b0;
      gnt_f_q  <= 1'b0;
      gnt_e_q  <= 1'b0;
      done_f_q <= 1'b0;
      done_e_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      sel_q    <= sel_d;
      op_sel_q <= op_sel_d;
      // Outputs are decoded from next state so every port comes straight from a flop.
      cs_q     <= (state_d == StIssue) || (state_d == StWait);
      gnt_f_q  <= (state_d != StIdle) && (owner_d == OwnF);
      gnt_e_q  <= (state_d != StIdle) && (owner_d == OwnE);
      done_f_q <= (state_d == StDone) && (owner_d == OwnF);
      done_e_q <= (state_d == StDone) && (owner_d == OwnE);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign cs_biu = cs_q;
  assign gnt_f  = gnt_f_q;
  assign gnt_e  = gnt_e_q;
  assign done_f = done_f_q;
  assign done_e = done_e_q;
  assign busy   = busy_q;
  assign sel    = sel_q;
  assign op_sel = op_sel_q;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) !(gnt_f && gnt_e));
  cs_busy_a:    assert property (@(posedge clk) disable iff (rst) cs_biu |-> busy);

endmodule

// File: doc/biu_arbiter.md
# biu_arbiter

Arbitrates the single bus interface unit between two requesters: the instruction fetch path and the execution unit. It latches the winning requester's `sel`/`op_sel`, drives the BIU chip-select handshake, and returns a per-requester completion pulse. A lock input lets the execution unit hold the BIU across a multi-transfer sequence (operand A read, operand B read, result write). It sits between the fetch/EU control FSMs and the BIU.

## Interface
- No parameters.
- `clk` in 1 — single clock, all state on posedge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_f` in 1 — fetch requests a BIU transfer; held high until `done_f`.
- `sel_f` in 2 — fetch transfer select.
- `op_sel_f` in 2 — fetch operand/direction select.
- `gnt_f` out 1 — fetch owns BIU.
- `done_f` out 1 — one-cycle pulse, fetch transfer complete.
- `req_e`, `sel_e`, `op_sel_e`, `gnt_e`, `done_e` — same as above for the EU.
- `lock_e` in 1 — EU keeps ownership after its current transfer.
- `cs_biu` out 1 — BIU chip select.
- `sel` out 2, `op_sel` out 2 — forwarded from owner, registered at grant.
- `ready_biu` in 1 — BIU level: high = idle/complete, low = transfer in progress.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req_*` high, pick winner, latch its `sel`/`op_sel` into `sel`/`op_sel`, set `gnt_*`, go to ISSUE. Otherwise stay.
- ISSUE: `cs_biu`=1. On `ready_biu`=0 (BIU accepted), go to WAIT. Otherwise stay; there is no timeout.
- WAIT: `cs_biu`=1. On `ready_biu`=1, go to DONE.
- DONE: `cs_biu`=0, pulse owner's `done_*` for exactly this cycle.
  - If owner is EU with `lock_e`=1 and `req_e`=1: relatch `sel_e`/`op_sel_e`, keep `gnt_e`, go to ISSUE.
  - Otherwise: clear `gnt_*`, go to IDLE.
- Requester inputs are ignored in DONE except for the EU lock case. Requesters drop `req` at the edge where they sample `done`.
- Exactly one `gnt_*` is high at any time, or none.
- Priority:
  - Default: fixed, EU over fetch.
  - Optional round-robin mode, see Configuration.
- A `req` that falls while its owner is in ISSUE/WAIT does not abort the transfer; the transfer completes and `done` still pulses.
- `lock_e` is sampled only in DONE. `lock_e` without `req_e` releases the BIU.
- `lock_e` has no effect when fetch is the owner.

## Timing
- Reset (asynchronous, immediate, including mid-transfer): state IDLE; `cs_biu`, `sel`, `op_sel`, `gnt_f`, `gnt_e`, `done_f`, `done_e`, `busy` all 0.
- `req` high at edge k in IDLE → `gnt`, `cs_biu`, `sel`, `op_sel` valid after edge k.
- Minimum transfer is 3 cycles (ISSUE, WAIT, DONE) when the BIU drops `ready_biu` in the first ISSUE cycle and raises it in the first WAIT cycle.
- Unlocked back-to-back transfers cost one IDLE cycle between DONE and the next ISSUE.
- Locked EU transfers go DONE→ISSUE with no IDLE gap.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `sel`/`op_sel` are stable from grant to DONE. Changes on `sel_*`/`op_sel_*` after grant are ignored.

## Configuration
- `BIU_RR_ARB_EN` defined:
  - Round-robin arbitration. A 1-bit last-served register is updated in DONE.
  - On simultaneous requests, the requester not last served wins.
  - Reset value of last-served = fetch, so the EU wins the first tie.
  - Locked EU continuation does not consult priority.
- Undefined: fixed EU-over-fetch priority; no last-served register.

## Test plan
- Single fetch: `req_f`=1, `sel_f`=2'b10, `op_sel_f`=2'b00; BIU drops ready 1 cycle later and raises it 2 cycles later → `gnt_f` high 4 cycles, `sel`=2'b10 throughout, one `done_f` pulse, back to IDLE.
- Simultaneous `req_f`/`req_e`, fixed mode, repeated 3 times → EU served every time, fetch only after `req_e` stays low. Under `BIU_RR_ARB_EN` → grants alternate E, F, E.
- EU locked sequence: `op_sel_e` = 00, 01, 10 over three transfers with `lock_e`=1 on the first two, and `req_f` high throughout → three EU transfers with no IDLE between them, then fetch granted.
- Stalled BIU: `ready_biu` held high for 10 cycles in ISSUE → `cs_biu` stays 1, no `done`. Then drop and raise `ready_biu` → normal completion.
- Reset mid-WAIT: assert `rst` between edges → `cs_biu`, `gnt_*`, `busy` go 0 immediately. After release, pending `req_e` is granted on the next edge.
- `req_e` dropped during WAIT → transfer completes and `done_e` pulses once, with no second grant.
